// File: rtl/vga_timing_gen.sv
// Raster timing for the colour mapper: pixel-rate enable, DrawX/DrawY counters,
// active-video qualifier, sync pair delayed to line up with registered RGB, and line/frame pulses.
module vga_timing_gen #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_DLY = 1
) (
    input  logic       CLK,
    input  logic       Reset,
    output logic       pixel_ce,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       line_start,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);

    // Comparisons are done one bit wider so a 1024-wide region still decodes correctly.
    localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE);
    localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC);

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
            $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
        end
        if (CLK_DIV < 1) begin : g_bad_div
            $error("vga_timing_gen: CLK_DIV must be at least 1");
        end
        if (SYNC_DLY < 0 || SYNC_DLY > 7) begin : g_bad_dly
            $error("vga_timing_gen: SYNC_DLY must be in 0..7");
        end
    endgenerate

    logic [DIV_W-1:0] div_cnt_reg;
    logic             pixel_ce_reg;
    logic [9:0]       x_cnt_reg;
    logic [9:0]       y_cnt_reg;
    logic             line_start_reg;
    logic             frame_start_reg;
    logic             hs_raw;
    logic             vs_raw;
    logic             x_last;
    logic             y_last;

    // Pixel enable is registered, so it is high the cycle after the divider hits its last count.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            div_cnt_reg  <= '0;
            pixel_ce_reg <= 1'b0;
        end else begin
            pixel_ce_reg <= (div_cnt_reg == DIV_LAST);
            if (div_cnt_reg == DIV_LAST) begin
                div_cnt_reg <= '0;
            end else begin
                div_cnt_reg <= div_cnt_reg + DIV_W'(1);
            end
        end
    end

    assign x_last = (x_cnt_reg == H_LAST);
    assign y_last = (y_cnt_reg == V_LAST);

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            x_cnt_reg       <= '0;
            y_cnt_reg       <= '0;
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
            if (pixel_ce_reg) begin
                if (x_last) begin
                    x_cnt_reg      <= '0;
                    line_start_reg <= 1'b1;
                    if (y_last) begin
                        y_cnt_reg       <= '0;
                        frame_start_reg <= 1'b1;
                    end else begin
                        y_cnt_reg <= y_cnt_reg + 10'd1;
                    end
                end else begin
                    x_cnt_reg <= x_cnt_reg + 10'd1;
                end
            end
        end
    end

    assign blank  = ({1'b0, x_cnt_reg} < H_ACT_END) && ({1'b0, y_cnt_reg} < V_ACT_END);
    assign hs_raw = !(({1'b0, x_cnt_reg} >= H_SYNC_BEG) && ({1'b0, x_cnt_reg} < H_SYNC_END));
    assign vs_raw = !(({1'b0, y_cnt_reg} >= V_SYNC_BEG) && ({1'b0, y_cnt_reg} < V_SYNC_END));

    // Sync delay counts pixel ticks, so the shift register only moves on pixel_ce.
    generate
        if (SYNC_DLY == 0) begin : g_no_dly
            assign hs = hs_raw;
            assign vs = vs_raw;
        end else begin : g_dly
            logic [SYNC_DLY-1:0] hs_dly_reg;
            logic [SYNC_DLY-1:0] vs_dly_reg;

            always_ff @(posedge CLK or posedge Reset) begin
                if (Reset) begin
                    hs_dly_reg <= '1;
                    vs_dly_reg <= '1;
                end else if (pixel_ce_reg) begin
                    hs_dly_reg[0] <= hs_raw;
                    vs_dly_reg[0] <= vs_raw;
                    for (int i = 1; i < SYNC_DLY; i++) begin
                        hs_dly_reg[i] <= hs_dly_reg[i-1];
                        vs_dly_reg[i] <= vs_dly_reg[i-1];
                    end
                end
            end

            assign hs = hs_dly_reg[SYNC_DLY-1];
            assign vs = vs_dly_reg[SYNC_DLY-1];
        end
    endgenerate

    assign pixel_ce    = pixel_ce_reg;
    assign DrawX       = x_cnt_reg;
    assign DrawY       = y_cnt_reg;
    assign line_start  = line_start_reg;
    assign frame_start = frame_start_reg;

endmodule
